vga_axis_timing: RTL and testbench
==================================

# vga_axis_timing

Parametrised single-axis VGA timing generator: a position counter plus a four-phase state machine that decodes the active, front-porch, sync and back-porch segments of one scan axis. It also provides a run-time programmable position compare. One instance with `ce` tied high is the horizontal axis. A second instance, with `ce` driven by the first instance's `wrap`, is the vertical axis. Its outputs feed the pixel pipeline and the VGA connector syncs.

## Interface
Parameters:
- `WIDTH`, 11: counter, `pos` and `cmp_val` width.
- `ACTIVE`, 640: visible positions per period.
- `FRONT`, 16: front-porch length.
- `SYNC`, 96: sync pulse length.
- `BACK`, 48: back-porch length.
- `SYNC_POL`, 0: sync asserted level (0 = active-low, 1 = active-high).

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `ce`, in, 1: advance enable; the counter steps only on cycles where `ce`=1.
- `cmp_val`, in, `WIDTH`: run-time compare position.
- `pos`, out, `WIDTH`: current position, 0..TOTAL-1.
- `phase`, out, 2: current segment; 0=ACTIVE, 1=FRONT, 2=SYNC, 3=BACK.
- `active`, out, 1: high while `phase`=ACTIVE.
- `sync`, out, 1: equals `SYNC_POL` while `phase`=SYNC, otherwise `~SYNC_POL`.
- `wrap`, out, 1: end-of-period strobe.
- `cmp_hit`, out, 1: high when `pos`==`cmp_val`.

## Operation
- TOTAL = ACTIVE+FRONT+SYNC+BACK.
  - Each segment length must be ≥1.
  - TOTAL must be ≤ 2^WIDTH.
  - A violation is an elaboration-time error.
- Internal boundaries: E1=ACTIVE, E2=E1+FRONT, E3=E2+SYNC, E4=TOTAL.
  - Compute boundaries at WIDTH+1 bits so that TOTAL=2^WIDTH does not overflow.
- Counter behaviour on a `ce` cycle:
  - If `pos`=TOTAL-1, `pos` becomes 0.
  - Otherwise `pos` becomes `pos`+1.
  - On a cycle with `ce`=0, all registers hold.
- The state machine advances only when `ce`=1. Transitions are computed from the next `pos` value, so `phase` always agrees with `pos` in the same cycle:
  - ACTIVE→FRONT when next pos=E1.
  - FRONT→SYNC when next pos=E2.
  - SYNC→BACK when next pos=E3.
  - BACK→ACTIVE on wrap to 0.
  - No other transitions exist.
- `phase`, `active` and `sync` are registered outputs. Combinational decode of `pos` is not permitted for these, so the connector pins are glitch-free.
- `wrap` is combinational: `ce` AND (`pos`==TOTAL-1). It is intended to drive the next axis's `ce`.
- `cmp_hit` is combinational.
  - It is an unsigned full-width equality test.
  - `cmp_val` ≥ TOTAL never hits.
  - It is independent of `ce`.
- Reset takes priority over `ce`. On a `rst` cycle the next state is:
  - `pos`=0, `phase`=ACTIVE, `active`=1, `sync`=~SYNC_POL.
  - `wrap`=0 while `rst` is high, regardless of `ce`.
  - `cmp_hit` is high after reset iff `cmp_val`=0.
- Reset mid-period abandons the current period with no partial-sync extension. The next `ce` after reset release moves `pos` to 1.

## Timing
- Latency: `pos`, `phase`, `active` and `sync` all change on the same edge, following the `ce` cycle that caused the change.
- `wrap` and `cmp_hit` are valid in the same cycle as their inputs (zero latency).
- Chained vertical instance:
  - Its `pos` increments on the edge that returns horizontal `pos` to 0.
  - Both axes therefore wrap together at the frame end.
- `ce` may be any duty cycle (for example a pixel-clock enable from a divider). All outputs are stable between `ce` pulses.
- `cmp_val` may change at any cycle; `cmp_hit` follows immediately.

## Test plan
- Reset, then `ce`=1 continuously with defaults:
  - `active` is 1 for `pos` 0..639 and 0 from 640.
  - `sync` is 0 exactly for `pos` 656..751.
  - `wrap` pulses once every 800 cycles, at `pos`=799.
  - `pos` returns to 0 on the next edge.
- `ce` toggled 1-of-4 cycles:
  - `pos` advances once per `ce` pulse; all outputs hold otherwise.
  - `wrap` is high only in the `ce` cycle at `pos`=799.
  - The period is 3200 clocks.
- Vertical chaining with ACTIVE=480, FRONT=10, SYNC=2, BACK=33, vertical `ce` driven by horizontal `wrap`:
  - Vertical `sync` is low for exactly 2×800 clocks.
  - The frame is 525×800 = 420000 clocks.
- `rst` asserted at `pos`=700 (in SYNC) with `ce`=1:
  - The next edge gives `pos`=0, `sync`=1, `active`=1, `phase`=0.
  - `wrap` stays 0 during reset.
- `cmp_val`:
  - `cmp_val`=100: `cmp_hit` is high for exactly the one `pos`=100 cycle group per period.
  - `cmp_val`=900: never hits.
  - Changing `cmp_val` to the current `pos` asserts `cmp_hit` in the same cycle.
- Boundary parameters:
  - WIDTH=4, segments 4/4/4/4: TOTAL=16 wraps from 15 to 0 without overflow.
  - SYNC_POL=1 inverts only `sync`.

Source files
------------

// File: rtl/vga_axis_timing.sv
// Single-axis VGA timing generator: position counter plus a four-phase
// segment decoder (active, front porch, sync, back porch) with a run-time
// position compare. Chain two instances (horizontal wrap_o -> vertical ce_i)
// to build a full frame.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   PH_ACTIVE | visible region, pos 0 .. E1-1
//   PH_FRONT  | front porch,    pos E1 .. E2-1
//   PH_SYNC   | sync pulse,     pos E2 .. E3-1
//   PH_BACK   | back porch,     pos E3 .. TOTAL-1
module vga_axis_timing #(
  parameter int unsigned WIDTH    = 11,
  parameter int unsigned ACTIVE   = 640,
  parameter int unsigned FRONT    = 16,
  parameter int unsigned SYNC     = 96,
  parameter int unsigned BACK     = 48,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  output logic [WIDTH-1:0] pos_o,
  output logic [1:0]       phase_o,
  output logic             active_o,
  output logic             sync_o,
  output logic             wrap_o,
  output logic             cmp_hit_o
);

  localparam int unsigned     TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam longint unsigned CAP   = 64'd1 << WIDTH;

  generate
    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1 ||
        longint'(TOTAL) > CAP) begin : g_bad_params
      $error("vga_axis_timing: segment lengths must be >= 1 and TOTAL <= 2**WIDTH");
    end
  endgenerate

  // Boundaries carry one spare bit so TOTAL == 2**WIDTH is representable.
  localparam logic [WIDTH:0] E1   = (WIDTH+1)'(ACTIVE);
  localparam logic [WIDTH:0] E2   = (WIDTH+1)'(ACTIVE + FRONT);
  localparam logic [WIDTH:0] E3   = (WIDTH+1)'(ACTIVE + FRONT + SYNC);
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             active_q, active_d;
  logic             sync_q, sync_d;

  logic             at_last;
  logic [WIDTH-1:0] pos_inc;
  logic [WIDTH:0]   pos_nxt;

  assign at_last = ({1'b0, pos_q} == LAST);
  assign pos_inc = at_last ? '0 : pos_q + WIDTH'(1);
  assign pos_nxt = {1'b0, pos_inc};

  // Next-state: the phase follows the position the counter is about to take,
  // so registered phase/active/sync always line up with pos.
  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    if (ce_i) begin
      pos_d = pos_inc;
      unique case (phase_q)
        PH_ACTIVE: if (pos_nxt == E1)  phase_d = PH_FRONT;
        PH_FRONT:  if (pos_nxt == E2)  phase_d = PH_SYNC;
        PH_SYNC:   if (pos_nxt == E3)  phase_d = PH_BACK;
        PH_BACK:   if (pos_nxt == '0) phase_d = PH_ACTIVE;
      endcase
    end
    active_d = (phase_d == PH_ACTIVE);
    sync_d   = (phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  // State and registered outputs; reset wins over ce.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q    <= '0;
      phase_q  <= PH_ACTIVE;
      active_q <= 1'b1;
      sync_q   <= ~SYNC_POL;
    end else begin
      pos_q    <= pos_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign pos_o     = pos_q;
  assign phase_o   = phase_q;
  assign active_o  = active_q;
  assign sync_o    = sync_q;
  assign wrap_o    = ce_i & at_last & ~rst_i;
  assign cmp_hit_o = (cmp_val_i == pos_q);

endmodule

// File: tb/tb_vga_axis_timing.sv
module tb_vga_axis_timing;

  localparam int H_A = 640, H_F = 16, H_S = 96, H_B = 48, H_T = 800;
  localparam int S_A = 4,   S_F = 4,  S_S = 4,  S_B = 4,  S_T = 16;
  localparam int V_A = 480, V_F = 10, V_S = 2,  V_B = 33, V_T = 525;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_h = 1'b1, ce_h = 1'b0, rst_s = 1'b1, ce_s = 1'b0;
  logic [10:0] cmp_h = '0;
  logic [3:0]  cmp_s = '0;
  logic [9:0]  cmp_v = '0;

  logic [10:0] pos_h;  logic [1:0] ph_h;  logic act_h,  syn_h,  wr_h,  hit_h;
  logic [3:0]  pos_s;  logic [1:0] ph_s;  logic act_s,  syn_s,  wr_s,  hit_s;
  logic [3:0]  pos_p;  logic [1:0] ph_p;  logic act_p,  syn_p,  wr_p,  hit_p;
  logic [9:0]  pos_v;  logic [1:0] ph_v;  logic act_v,  syn_v,  wr_v,  hit_v;

  vga_axis_timing u_h (
    .clk_i(clk), .rst_i(rst_h), .ce_i(ce_h), .cmp_val_i(cmp_h),
    .pos_o(pos_h), .phase_o(ph_h), .active_o(act_h), .sync_o(syn_h),
    .wrap_o(wr_h), .cmp_hit_o(hit_h));

  vga_axis_timing #(.WIDTH(4), .ACTIVE(S_A), .FRONT(S_F), .SYNC(S_S), .BACK(S_B), .SYNC_POL(1'b0)) u_s (
    .clk_i(clk), .rst_i(rst_s), .ce_i(ce_s), .cmp_val_i(cmp_s),
    .pos_o(pos_s), .phase_o(ph_s), .active_o(act_s), .sync_o(syn_s),
    .wrap_o(wr_s), .cmp_hit_o(hit_s));

  vga_axis_timing #(.WIDTH(4), .ACTIVE(S_A), .FRONT(S_F), .SYNC(S_S), .BACK(S_B), .SYNC_POL(1'b1)) u_p (
    .clk_i(clk), .rst_i(rst_s), .ce_i(ce_s), .cmp_val_i(cmp_s),
    .pos_o(pos_p), .phase_o(ph_p), .active_o(act_p), .sync_o(syn_p),
    .wrap_o(wr_p), .cmp_hit_o(hit_p));

  vga_axis_timing #(.WIDTH(10), .ACTIVE(V_A), .FRONT(V_F), .SYNC(V_S), .BACK(V_B), .SYNC_POL(1'b0)) u_v (
    .clk_i(clk), .rst_i(rst_s), .ce_i(wr_s), .cmp_val_i(cmp_v),
    .pos_o(pos_v), .phase_o(ph_v), .active_o(act_v), .sync_o(syn_v),
    .wrap_o(wr_v), .cmp_hit_o(hit_v));

  int n_assert = 0, n_fail = 0;

  // reference positions
  int m_h = 0, m_s = 0, m_v = 0;

  // aggregate counters (sampled before each edge)
  int c_hit = 0, c_hlo = 0, c_hact = 0, c_hwrap = 0;
  int s_steps = 0, c_vlo = 0, c_vwrap = 0, c_swrap = 0;

  function automatic int seg(input int p, input int a, input int f, input int s);
    if (p < a)           return 0;
    else if (p < a + f)  return 1;
    else if (p < a+f+s)  return 2;
    else                 return 3;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    int e;
    e = seg(m_h, H_A, H_F, H_S);
    chk("h_pos", int'(pos_h), m_h);
    chk("h_phase", int'(ph_h), e);
    chk("h_active", int'(act_h), (e == 0) ? 1 : 0);
    chk("h_sync", int'(syn_h), (e == 2) ? 0 : 1);
    e = seg(m_s, S_A, S_F, S_S);
    chk("s_pos", int'(pos_s), m_s);
    chk("s_phase", int'(ph_s), e);
    chk("s_active", int'(act_s), (e == 0) ? 1 : 0);
    chk("s_sync", int'(syn_s), (e == 2) ? 0 : 1);
    chk("p_pos", int'(pos_p), m_s);
    chk("p_phase", int'(ph_p), e);
    chk("p_active", int'(act_p), (e == 0) ? 1 : 0);
    chk("p_sync", int'(syn_p), (e == 2) ? 1 : 0);
    e = seg(m_v, V_A, V_F, V_S);
    chk("v_pos", int'(pos_v), m_v);
    chk("v_phase", int'(ph_v), e);
    chk("v_active", int'(act_v), (e == 0) ? 1 : 0);
    chk("v_sync", int'(syn_v), (e == 2) ? 0 : 1);
  endtask

  // One clock: drive inputs, check zero-latency outputs, advance the model.
  task automatic step(input bit ceh, input bit rh);
    bit ws;
    ce_h = ceh; rst_h = rh; ce_s = 1'b1; rst_s = 1'b0;
    #1;
    ws = (m_s == S_T - 1);
    chk("h_wrap", int'(wr_h), (ceh && !rh && m_h == H_T - 1) ? 1 : 0);
    chk("h_cmp", int'(hit_h), (int'(cmp_h) == m_h) ? 1 : 0);
    chk("s_wrap", int'(wr_s), ws ? 1 : 0);
    chk("s_cmp", int'(hit_s), (int'(cmp_s) == m_s) ? 1 : 0);
    chk("v_wrap", int'(wr_v), (ws && m_v == V_T - 1) ? 1 : 0);
    chk("v_cmp", int'(hit_v), (int'(cmp_v) == m_v) ? 1 : 0);
    c_hit  += int'(hit_h);
    c_hlo  += (syn_h == 1'b0) ? 1 : 0;
    c_hact += int'(act_h);
    c_hwrap += int'(wr_h);
    if (s_steps < S_T * V_T) begin
      c_vlo   += (syn_v == 1'b0) ? 1 : 0;
      c_vwrap += int'(wr_v);
      c_swrap += int'(wr_s);
    end
    s_steps++;
    @(posedge clk);
    if (ws) m_v = (m_v + 1) % V_T;
    m_s = (m_s + 1) % S_T;
    if (rh)       m_h = 0;
    else if (ceh) m_h = (m_h + 1) % H_T;
    #1;
    check_regs();
    if ($urandom_range(0, 15) == 0) cmp_s = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 31) == 0) cmp_v = 10'($urandom_range(0, 600));
  endtask

  task automatic clr();
    c_hit = 0; c_hlo = 0; c_hact = 0; c_hwrap = 0;
  endtask

  initial begin
    int n;
    rst_h = 1'b1; rst_s = 1'b1; ce_h = 1'b1; ce_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_regs();

    // reset held with ce high: wrap must stay low
    step(1'b1, 1'b1);

    // continuous ce, compare at 100
    cmp_h = 11'd100;
    clr();
    repeat (H_T) step(1'b1, 1'b0);
    chk("h_period_hits", c_hit, 1);
    chk("h_sync_low_cnt", c_hlo, H_S);
    chk("h_active_cnt", c_hact, H_A);
    chk("h_wrap_cnt", c_hwrap, 1);

    // compare beyond TOTAL never hits
    cmp_h = 11'd900;
    clr();
    repeat (H_T) step(1'b1, 1'b0);
    chk("h_cmp900_hits", c_hit, 0);

    // ce one cycle in four: one period spans 3200 clocks
    clr();
    for (int i = 0; i < 4 * H_T; i++) step((i % 4) == 0, 1'b0);
    chk("h_div4_wrap_cnt", c_hwrap, 1);
    chk("h_div4_sync_low", c_hlo, 4 * H_S);

    // random ce duty with random compare values, sometimes the current pos
    for (int i = 0; i < 2000; i++) begin
      n = int'($urandom_range(0, 7));
      if (n == 0)      cmp_h = 11'(m_h);
      else if (n == 1) cmp_h = 11'($urandom_range(0, 2047));
      step($urandom_range(0, 2) == 0, 1'b0);
    end

    // reset in the middle of sync
    n = 0;
    while (m_h != 700 && n < 2 * H_T) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("reach_pos700", m_h, 700);
    chk("pre_rst_sync", int'(syn_h), 0);
    step(1'b1, 1'b1);
    chk("rst_pos", int'(pos_h), 0);
    chk("rst_sync", int'(syn_h), 1);
    step(1'b1, 1'b0);
    chk("post_rst_pos", int'(pos_h), 1);

    // let the chained pair finish its first full frame
    while (s_steps < S_T * V_T + 20) step($urandom_range(0, 1) == 1, 1'b0);
    chk("v_sync_low_clocks", c_vlo, V_S * S_T);
    chk("v_frame_wraps", c_vwrap, 1);
    chk("s_wraps_per_frame", c_swrap, V_T);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
